// File: rtl/i2s_ctrl.sv
// I2S master controller: generates bck/lrck from mck, deserialises sdin into
// left/right sample pairs with a valid/ready handshake, and serialises tx samples.
module i2s_ctrl #(
   parameter int unsigned BCK_DIV   = 2,
   parameter int unsigned WIDTH     = 24,
   parameter int unsigned SLOT_BITS = 32
) (
   input  logic             mck,
   input  logic             rst_n,
   input  logic             enable,
   output logic             bck,
   output logic             lrck,
   input  logic             sdin,
   output logic             sdout,
   output logic [WIDTH-1:0] rx_l,
   output logic [WIDTH-1:0] rx_r,
   output logic             rx_valid,
   input  logic             rx_ready,
   input  logic [WIDTH-1:0] tx_l,
   input  logic [WIDTH-1:0] tx_r,
   output logic             tx_load,
   output logic             overrun,
   input  logic             clr_overrun
);

   localparam int unsigned DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
   localparam int unsigned BIT_W = $clog2(SLOT_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_WORD = BIT_W'(WIDTH);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             bck_q, bck_d, lrck_q, lrck_d, sdout_q, sdout_d;
   logic [WIDTH-1:0] shift_q, shift_d, hold_q, hold_d;
   logic [WIDTH-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
   logic             rx_valid_q, rx_valid_d, overrun_q, overrun_d;
   logic [WIDTH-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d, tx_sh_q, tx_sh_d;
   logic             tx_load_q, tx_load_d;

   logic             tick, bck_rise, bck_fall, frame_done, overrun_set;
   logic [WIDTH-1:0] shift_in, tx_cur;

   always_comb begin
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      bck_d       = bck_q;
      lrck_d      = lrck_q;
      sdout_d     = sdout_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      rx_l_d      = rx_l_q;
      rx_r_d      = rx_r_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = overrun_q;
      tx_l_d      = tx_l_q;
      tx_r_d      = tx_r_q;
      tx_sh_d     = tx_sh_q;
      tx_load_d   = 1'b0;
      frame_done  = 1'b0;
      overrun_set = 1'b0;
      tx_cur      = lrck_q ? tx_r_q : tx_l_q;
      tick        = enable && (div_cnt_q == DIV_LAST);
      bck_rise    = tick && !bck_q;
      bck_fall    = tick && bck_q;
      shift_in    = WIDTH'({shift_q, sdin});

      if (enable) begin
         div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
         if (tick) bck_d = ~bck_q;
         // Slot/frame sequencing and transmit serialiser advance on bck fall
         if (bck_fall) begin
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               lrck_d    = ~lrck_q;
               if (lrck_q) begin
                  tx_l_d    = tx_l;
                  tx_r_d    = tx_r;
                  tx_load_d = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
            if (bit_cnt_d == BIT_W'(1)) begin
               sdout_d = tx_cur[WIDTH-1];
               tx_sh_d = tx_cur << 1;
            end else if (bit_cnt_d >= BIT_W'(2) && bit_cnt_d <= BIT_WORD) begin
               sdout_d = tx_sh_q[WIDTH-1];
               tx_sh_d = tx_sh_q << 1;
            end else begin
               sdout_d = 1'b0;
            end
         end
         // One-bit I2S delay: slot bit 0 is skipped, bits 1..WIDTH are captured
         if (bck_rise && bit_cnt_q != '0 && bit_cnt_q <= BIT_WORD) begin
            shift_d = shift_in;
            if (bit_cnt_q == BIT_WORD) begin
               if (lrck_q) frame_done = 1'b1;
               else        hold_d     = shift_in;
            end
         end
      end else begin
         div_cnt_d = '0;
         bit_cnt_d = '0;
         bck_d     = 1'b0;
         lrck_d    = 1'b0;
         sdout_d   = 1'b0;
         shift_d   = '0;
         hold_d    = '0;
         tx_sh_d   = '0;
      end

      // Output handshake; a completing frame overrides the consumption clear
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      if (frame_done) begin
         if (rx_valid_q && !rx_ready) begin
            overrun_set = 1'b1;
         end else begin
            rx_l_d     = hold_q;
            rx_r_d     = shift_in;
            rx_valid_d = 1'b1;
         end
      end
      if (clr_overrun) overrun_d = 1'b0;
      if (overrun_set) overrun_d = 1'b1;
   end

   always_ff @(posedge mck or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         bck_q      <= 1'b0;
         lrck_q     <= 1'b0;
         sdout_q    <= 1'b0;
         shift_q    <= '0;
         hold_q     <= '0;
         rx_l_q     <= '0;
         rx_r_q     <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         tx_l_q     <= '0;
         tx_r_q     <= '0;
         tx_sh_q    <= '0;
         tx_load_q  <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         bck_q      <= bck_d;
         lrck_q     <= lrck_d;
         sdout_q    <= sdout_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         rx_l_q     <= rx_l_d;
         rx_r_q     <= rx_r_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         tx_l_q     <= tx_l_d;
         tx_r_q     <= tx_r_d;
         tx_sh_q    <= tx_sh_d;
         tx_load_q  <= tx_load_d;
      end
   end

   assign bck      = bck_q;
   assign lrck     = lrck_q;
   assign sdout    = sdout_q;
   assign rx_l     = rx_l_q;
   assign rx_r     = rx_r_q;
   assign rx_valid = rx_valid_q;
   assign tx_load  = tx_load_q;
   assign overrun  = overrun_q;

endmodule

// File: doc/i2s_ctrl.md
I2S_CTRL -- requirements
Module: i2s_ctrl

Interface
REQ-001 Parameter BCK_DIV, default 2: mck cycles per bck half-period; legal range >=1.
REQ-002 Parameter WIDTH, default 24: sample bits per channel.
REQ-003 Parameter SLOT_BITS, default 32: bck cycles per channel slot; legal range >= WIDTH+1.
REQ-004 mck  in  1  master clock; all state changes on rising mck.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 enable  in  1  run control; low = synchronous return to idle.
REQ-007 bck  out  1  generated bit clock.
REQ-008 lrck  out  1  generated frame clock; 0 = left slot, 1 = right slot.
REQ-009 sdin  in  1  serial ADC data, MSB first, I2S format.
REQ-010 sdout  out  1  serial DAC data, MSB first, I2S format.
REQ-011 rx_l, rx_r  out  WIDTH each  received left/right sample pair.
REQ-012 rx_valid  out  1  rx pair available.
REQ-013 rx_ready  in  1  consumer accepts rx pair.
REQ-014 tx_l, tx_r  in  WIDTH each  samples to transmit.
REQ-015 tx_load  out  1  one-cycle pulse: tx_l/tx_r latched this cycle.
REQ-016 overrun  out  1  sticky: a received frame was dropped.
REQ-017 clr_overrun  in  1  synchronous clear of overrun.

Function
REQ-018 Divider div_cnt counts 0..BCK_DIV-1 while enable=1; at BCK_DIV-1 it wraps to 0 and bck toggles.
REQ-019 Edge events: "bck rise" = mck edge where bck goes 0->1; "bck fall" = edge where bck goes 1->0.
REQ-020 bit_cnt (0..SLOT_BITS-1) increments on each bck fall; at SLOT_BITS-1 it wraps to 0 and lrck toggles on the same edge.
REQ-021 Defaults: bck period 4 mck, slot 32 bck = 128 mck, frame 256 mck.
REQ-022 Receive: on bck rise with bit_cnt in 1..WIDTH, sdin shifts into the rx shift register LSB end (one-bit I2S delay; bit_cnt=0 bit ignored).
REQ-023 On bck rise with bit_cnt=WIDTH and lrck=0, the shift register copies to an internal left hold register.
REQ-024 On bck rise with bit_cnt=WIDTH and lrck=1 ("frame complete"), rx_l <= left hold, rx_r <= shift register with the newest bit, rx_valid <= 1, same edge.
REQ-025 Handshake: transfer occurs on any mck edge with rx_valid=1 and rx_ready=1; rx_valid clears on that edge unless a frame completes on the same edge.
REQ-026 Frame complete with rx_valid=1 and rx_ready=0: new frame dropped, rx_l/rx_r unchanged, overrun <= 1.
REQ-027 Frame complete with rx_valid=1 and rx_ready=1: old pair consumed, new pair loaded, rx_valid stays 1, no overrun.
REQ-028 overrun clears on edge with clr_overrun=1; a simultaneous set wins (overrun stays 1).
REQ-029 Transmit: on bck fall where bit_cnt wraps and lrck goes 1->0, tx_l/tx_r latch into tx registers and tx_load pulses high for exactly that one mck cycle.
REQ-030 sdout updates only on bck fall: for new bit_cnt k in 1..WIDTH, sdout = bit WIDTH-k of the current channel's tx register; otherwise 0.
REQ-031 enable=0: div_cnt, bit_cnt, bck, lrck, sdout, shift and hold registers go to 0 on next edge; rx_l, rx_r, rx_valid, overrun, tx registers retained; handshake keeps operating.
REQ-032 On enable 0->1 sequencing restarts from bit_cnt=0, lrck=0 (left slot); first frame transmits tx register contents (0 after reset).

Reset
REQ-033 rst_n=0 asynchronously forces bck=0, lrck=0, sdout=0, rx_l=0, rx_r=0, rx_valid=0, tx_load=0, overrun=0, all counters and internal registers 0.
REQ-034 Reset asserted mid-frame discards any partial word; no rx_valid or tx_load from the interrupted frame.

Verification
REQ-035 Defaults, enable=1 after reset: bck toggles every 2 mck, lrck toggles every 128 mck, first lrck rise at mck edge 128 after enable.
REQ-036 Loopback sdout->sdin, tx_l=24'h888888, tx_r=24'h123456, rx_ready=1: second full frame yields rx_l=888888, rx_r=123456, rx_valid high one cycle per frame.
REQ-037 Model drives sdin left=24'hA5A5A5, right=24'h5A5A5A with rx_ready=0 for two frames: rx pair holds first frame, overrun=1; clr_overrun=1 one cycle -> overrun=0.
REQ-038 rx_ready pulsed on exact frame-complete edge with rx_valid=1: new pair loaded, rx_valid stays 1, overrun stays 0.
REQ-039 tx_l changed mid-frame from 24'h000001 to 24'hFFFFFF: sdout frame carries 000001; tx_load pulses once per 256 mck at left-slot start.
REQ-040 rst_n pulsed low, and separately enable dropped, at bit_cnt=10 of right slot: bck/lrck/sdout return to 0, no rx_valid from partial frame, clean restart from left slot.
